led_sequencer: RTL and testbench

Downstream consumer of the one-second timer. Gates the timer through `timer_en`, counts its `One_sec_timeout` ticks, and steps an LED pattern every `DWELL_SEC` seconds. Run/pause/stop control comes from the board push-button logic, and `leds` drives the board LEDs directly.

---
 rtl/led_sequencer.sv | 128 ++++++++++++
 tb/tb_led_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/led_sequencer.sv
// LED pattern sequencer driven by the one-second timer: counts timer ticks and
// steps one of four LED patterns every DWELL_SEC ticks, with run/pause/stop control.
module led_sequencer #(
  parameter int unsigned NUM_LEDS  = 8,
  parameter int unsigned DWELL_SEC = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                pause,
  input  logic                stop,
  input  logic [1:0]          mode,
  input  logic                tick,
  output logic                timer_en,
  output logic [NUM_LEDS-1:0] leds,
  output logic                busy,
  output logic                step_pulse,
  output logic                wrap_pulse
);

  localparam int unsigned CntW = (DWELL_SEC > 1) ? $clog2(DWELL_SEC) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DWELL_SEC - 1);

  typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

  state_e              state_q;
  logic [1:0]          mode_q;
  logic                dir_q;  // bounce direction, 1 = towards bit N-1
  logic [CntW-1:0]     cnt_q;
  logic [NUM_LEDS-1:0] nxt_leds;
  logic                nxt_dir;

  function automatic logic [NUM_LEDS-1:0] init_pat(input logic [1:0] m);
    logic [NUM_LEDS-1:0] p;
    unique case (m)
      2'd0, 2'd1: p = NUM_LEDS'(1);
      2'd2:       p = '1;
      default:    p = '0;
    endcase
    return p;
  endfunction

  always_comb begin
    nxt_leds = leds;
    nxt_dir  = dir_q;
    unique case (mode_q)
      2'd0: nxt_leds = {leds[NUM_LEDS-2:0], leds[NUM_LEDS-1]};
      2'd1: begin
        // Reverse on reaching an end so the end position is shown only once.
        if (dir_q) begin
          nxt_leds = leds << 1;
          nxt_dir  = ~nxt_leds[NUM_LEDS-1];
        end else begin
          nxt_leds = leds >> 1;
          nxt_dir  = nxt_leds[0];
        end
      end
      2'd2:    nxt_leds = ~leds;
      default: nxt_leds = leds + NUM_LEDS'(1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      mode_q     <= 2'd0;
      dir_q      <= 1'b1;
      cnt_q      <= '0;
      leds       <= '0;
      timer_en   <= 1'b0;
      busy       <= 1'b0;
      step_pulse <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      wrap_pulse <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start && !stop) begin
            state_q  <= StRun;
            mode_q   <= mode;
            dir_q    <= 1'b1;
            cnt_q    <= '0;
            leds     <= init_pat(mode);
            timer_en <= 1'b1;
            busy     <= 1'b1;
          end
        end
        StRun: begin
          if (stop) begin
            state_q  <= StIdle;
            leds     <= '0;
            timer_en <= 1'b0;
            busy     <= 1'b0;
          end else begin
            if (tick) begin
              if (cnt_q == CntMax) begin
                cnt_q      <= '0;
                leds       <= nxt_leds;
                dir_q      <= nxt_dir;
                step_pulse <= 1'b1;
                wrap_pulse <= (nxt_leds == init_pat(mode_q));
              end else begin
                cnt_q <= cnt_q + CntW'(1);
              end
            end
            if (pause) begin
              state_q  <= StHold;
              timer_en <= 1'b0;
            end
          end
        end
        StHold: begin
          if (stop) begin
            state_q  <= StIdle;
            leds     <= '0;
            busy     <= 1'b0;
          end else if (pause) begin
            state_q  <= StRun;
            timer_en <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer: DWELL_SEC=2 instance for most scenarios,
// DWELL_SEC=1 instance for the bounce pattern.
module tb_led_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, pause, stop, tick;
  logic [1:0] mode;

  logic       timer_en, busy, step_pulse, wrap_pulse;
  logic [7:0] leds;
  logic       timer_en1, busy1, step_pulse1, wrap_pulse1;
  logic [7:0] leds1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  led_sequencer #(.NUM_LEDS(8), .DWELL_SEC(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop), .mode(mode),
    .tick(tick), .timer_en(timer_en), .leds(leds), .busy(busy),
    .step_pulse(step_pulse), .wrap_pulse(wrap_pulse)
  );

  led_sequencer #(.NUM_LEDS(8), .DWELL_SEC(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop), .mode(mode),
    .tick(tick), .timer_en(timer_en1), .leds(leds1), .busy(busy1),
    .step_pulse(step_pulse1), .wrap_pulse(wrap_pulse1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [1:0] m);
    start = 1'b1; mode = m; step(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1; step(); tick = 1'b0;
  endtask

  localparam logic [7:0] Bounce [14] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                         8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0; tick = 1'b0; mode = 2'd0;

    // Reset held 3 cycles with start/tick toggling
    for (int i = 0; i < 3; i++) begin
      start = (i % 2 == 0); tick = (i % 2 == 1); mode = 2'd2;
      step();
      check_eq("rst_leds", {24'd0, leds}, 32'h0);
      check_eq("rst_outs", {timer_en, busy, step_pulse, wrap_pulse}, 4'h0);
    end
    rst = 1'b0; start = 1'b0; tick = 1'b0;
    step();
    check_eq("idle_leds", {24'd0, leds}, 32'h0);

    // Idle ignores ticks
    do_tick();
    check_eq("idle_tick", {step_pulse, timer_en}, 2'b00);

    // Mode 0 rotate-left, 16 ticks
    pulse_start(2'd0);
    check_eq("m0_start_leds", {24'd0, leds}, 32'h01);
    check_eq("m0_start_ctl", {timer_en, busy}, 2'b11);
    for (int i = 1; i <= 16; i++) begin
      do_tick();
      check_eq("m0_leds", {24'd0, leds}, 32'(8'h01 << ((i / 2) % 8)));
      check_eq("m0_step", {31'd0, step_pulse}, 32'(i % 2 == 0));
      check_eq("m0_wrap", {31'd0, wrap_pulse}, 32'(i == 16));
    end
    step();
    check_eq("m0_pulse_drop", {step_pulse, wrap_pulse}, 2'b00);
    check_eq("m0_hold_val", {24'd0, leds}, 32'h01);

    // Mode 1 bounce on the DWELL_SEC=1 instance
    pulse_stop();
    check_eq("stop_dut1", {24'd0, leds1, 6'd0, busy1, timer_en1}, 32'h0);
    pulse_start(2'd1);
    check_eq("m1_start", {24'd0, leds1}, 32'h01);
    for (int i = 0; i < 14; i++) begin
      do_tick();
      check_eq("m1_leds", {24'd0, leds1}, {24'd0, Bounce[i]});
      check_eq("m1_step", {31'd0, step_pulse1}, 32'd1);
      check_eq("m1_wrap", {31'd0, wrap_pulse1}, 32'(i == 13));
    end

    // Pause: mode 3 to 0x05 with one tick pending
    pulse_stop();
    pulse_start(2'd3);
    check_eq("m3_start", {24'd0, leds}, 32'h00);
    for (int i = 0; i < 11; i++) do_tick();
    check_eq("m3_at5", {24'd0, leds}, 32'h05);
    pause = 1'b1; step(); pause = 1'b0;
    check_eq("hold_ctl", {timer_en, busy}, 2'b01);
    for (int i = 0; i < 5; i++) begin
      do_tick();
      check_eq("hold_leds", {24'd0, leds}, 32'h05);
      check_eq("hold_ten", {step_pulse, timer_en}, 2'b00);
    end
    pause = 1'b1; step(); pause = 1'b0;
    check_eq("resume_ten", {31'd0, timer_en}, 32'd1);
    do_tick();
    check_eq("resume_leds", {24'd0, leds}, 32'h06);
    check_eq("resume_step", {31'd0, step_pulse}, 32'd1);

    // stop collides with dwell-completing tick
    do_tick();
    check_eq("pre_stop", {24'd0, leds}, 32'h06);
    tick = 1'b1; stop = 1'b1; step(); tick = 1'b0; stop = 1'b0;
    check_eq("stop_tick_leds", {24'd0, leds}, 32'h0);
    check_eq("stop_tick_ctl", {step_pulse, timer_en, busy}, 3'b000);

    // pause collides with dwell-completing tick
    pulse_start(2'd3);
    do_tick();
    tick = 1'b1; pause = 1'b1; step(); tick = 1'b0; pause = 1'b0;
    check_eq("pause_tick_leds", {24'd0, leds}, 32'h01);
    check_eq("pause_tick_ctl", {step_pulse, timer_en, busy}, 3'b101);
    do_tick();
    do_tick();
    check_eq("pause_tick_hold", {24'd0, leds}, 32'h01);

    // Mid-run reset during mode 2 at all zeros
    pulse_stop();
    pulse_start(2'd2);
    check_eq("m2_start", {24'd0, leds}, 32'hFF);
    do_tick();
    do_tick();
    check_eq("m2_zero", {24'd0, leds}, 32'h00);
    check_eq("m2_nowrap", {step_pulse, wrap_pulse}, 2'b10);
    do_tick();
    rst = 1'b1; step(); rst = 1'b0;
    check_eq("midrst", {24'd0, leds}, 32'h0);
    check_eq("midrst_ctl", {timer_en, busy, step_pulse, wrap_pulse}, 4'h0);
    pulse_start(2'd0);
    check_eq("post_rst_start", {24'd0, leds}, 32'h01);
    do_tick();
    check_eq("post_rst_cnt", {23'd0, step_pulse, leds}, 32'h001);
    do_tick();
    check_eq("post_rst_step", {23'd0, step_pulse, leds}, 32'h102);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
